// File: rtl/cacheline_adapter_pkg.sv
// Shared constants, state encoding and helpers for the cache line adapter.
package cacheline_adapter_pkg;

  localparam int s_offset = 5;
  localparam int s_line   = 8 * (2 ** s_offset);
  localparam int s_burst  = 64;
  localparam int s_addr   = 32;
  localparam int beats    = s_line / s_burst;
  localparam int cnt_w    = $clog2(beats);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WB,
    DONE
  } adapter_state_t;

  typedef logic [cnt_w-1:0] beat_cnt_t;

  localparam beat_cnt_t last_beat = beat_cnt_t'(beats - 1);

  // Clears the byte-offset bits so memory always sees a line-aligned address.
  function automatic logic [s_addr-1:0] line_align(input logic [s_addr-1:0] a);
    logic [s_addr-1:0] mask;
    mask = s_addr'((1 << s_offset) - 1);
    return a & ~mask;
  endfunction

endpackage

// File: rtl/cacheline_adapter_if.sv
// Burst memory port between the adapter (master) and the memory (slave).
interface cacheline_adapter_if;
  import cacheline_adapter_pkg::*;

  logic [s_addr-1:0]  address_o;
  logic               read_o;
  logic               write_o;
  logic [s_burst-1:0] burst_o;
  logic [s_burst-1:0] burst_i;
  logic               resp_i;

  modport master (
    output address_o,
    output read_o,
    output write_o,
    output burst_o,
    input  burst_i,
    input  resp_i
  );

  modport slave (
    input  address_o,
    input  read_o,
    input  write_o,
    input  burst_o,
    output burst_i,
    output resp_i
  );

endinterface

// File: rtl/cacheline_adapter.sv
// Cache line adapter: assembles memory bursts into full cache lines on fills
// and streams evicted lines out as bursts on writebacks. One transaction at a
// time; the requester sees a single-cycle resp_o when it completes.
module cacheline_adapter
  import cacheline_adapter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [s_addr-1:0]  address_i,
  input  logic               read_i,
  input  logic               write_i,
  input  logic [s_line-1:0]  line_i,
  output logic [s_line-1:0]  line_o,
  output logic               resp_o,
  cacheline_adapter_if.master mem
);

  adapter_state_t    state_q, state_d;
  beat_cnt_t         cnt_q, cnt_d;
  logic [s_addr-1:0] addr_q, addr_d;
  logic [s_line-1:0] wbLine_q, wbLine_d;
  logic [s_line-1:0] fillLine_q, fillLine_d;

  // State, beat counter, latched address and both line buffers; reset wipes all.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wbLine_q   <= '0;
      fillLine_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wbLine_q   <= wbLine_d;
      fillLine_q <= fillLine_d;
    end
  end

  // Next-state logic: accept in IDLE (writeback wins), count beats on resp_i.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wbLine_d   = wbLine_q;
    fillLine_d = fillLine_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (write_i) begin
          wbLine_d = line_i;
          addr_d   = line_align(address_i);
          state_d  = WB;
        end else if (read_i) begin
          addr_d  = line_align(address_i);
          state_d = FILL;
        end
      end

      FILL: begin
        if (mem.resp_i) begin
          fillLine_d[cnt_q*s_burst +: s_burst] = mem.burst_i;
          if (cnt_q == last_beat) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      WB: begin
        if (mem.resp_i) begin
          if (cnt_q == last_beat) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decoded from the registered state so they never glitch on inputs.
  always_comb begin
    mem.address_o = addr_q;
    mem.read_o    = (state_q == FILL);
    mem.write_o   = (state_q == WB);
    mem.burst_o   = '0;
    if (state_q == WB) begin
      mem.burst_o = wbLine_q[cnt_q*s_burst +: s_burst];
    end
    resp_o = (state_q == DONE);
    line_o = fillLine_q;
  end

  // The two burst strobes must never be asserted together.
  assert property (@(posedge clk) disable iff (!rst) !(mem.read_o && mem.write_o));

  // The completion pulse lasts exactly one cycle.
  assert property (@(posedge clk) disable iff (!rst) resp_o |=> !resp_o);

endmodule

// File: tb/tb_cacheline_adapter.sv
// Self-checking bench for cacheline_adapter: directed scenarios plus a
// randomized mix, all compared against expectations built from the line/beat
// arithmetic directly.
module tb_cacheline_adapter;
  import cacheline_adapter_pkg::*;

  typedef struct packed {
    logic [s_line-1:0]                line;
    logic [s_addr-1:0]                addr;
    logic [beats-1:0][s_burst-1:0]    beatData;
    bit                               timeout;
    bit                               strobeOk;
    bit                               otherStrobe;
    bit                               respEarly;
    bit                               respDone;
    bit                               strobeAtDone;
    bit                               idleBusy;
    bit                               addrMoved;
    int                               cycles;
    int                               slots;
  } obs_t;

  logic              clk;
  logic              rst;
  logic [s_addr-1:0] address_i;
  logic              read_i;
  logic              write_i;
  logic [s_line-1:0] line_i;
  logic [s_line-1:0] line_o;
  logic              resp_o;

  cacheline_adapter_if mem ();

  int errors = 0;
  int checks = 0;
  logic [s_line-1:0] modelFill;

  cacheline_adapter dut (
    .clk       (clk),
    .rst       (rst),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .line_i    (line_i),
    .line_o    (line_o),
    .resp_o    (resp_o),
    .mem       (mem)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something hangs outside the bounded loops.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [s_line-1:0] rand256();
    logic [s_line-1:0] r;
    for (int i = 0; i < s_line / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [s_addr-1:0] expAddr(input logic [s_addr-1:0] a);
    return a - (a % s_addr'(2 ** s_offset));
  endfunction

  // Drives one transaction at negedges, acting as requester and memory, and
  // records what the DUT showed. The scenario tasks judge the observations.
  task automatic doTxn(input bit isWrite, input bit alsoOther,
                       input logic [s_addr-1:0] addr, input logic [s_line-1:0] data,
                       input bit randGaps, input int unsigned pat, input int patLen,
                       input bit hold, output obs_t o);
    int k;
    int idx;
    bit b;
    k = 0;
    idx = 0;
    o = '0;
    o.strobeOk = 1'b1;
    mem.resp_i  = 1'($urandom_range(0, 1));
    mem.burst_i = {$urandom, $urandom};
    address_i = addr;
    write_i   = isWrite;
    read_i    = !isWrite || alsoOther;
    line_i    = isWrite ? data : rand256();
    o.cycles  = 1;
    @(negedge clk);
    o.cycles++;
    address_i = $urandom;
    line_i    = rand256();
    o.addr    = mem.address_o;
    while (k < beats && o.slots < 200) begin
      if (isWrite) begin
        if (mem.write_o !== 1'b1) o.strobeOk = 1'b0;
        if (mem.read_o !== 1'b0) o.otherStrobe = 1'b1;
      end else begin
        if (mem.read_o !== 1'b1) o.strobeOk = 1'b0;
        if (mem.write_o !== 1'b0) o.otherStrobe = 1'b1;
      end
      if (resp_o !== 1'b0) o.respEarly = 1'b1;
      if (mem.address_o !== o.addr) o.addrMoved = 1'b1;
      if (randGaps) b = ($urandom_range(0, 3) != 0);
      else if (idx < patLen) b = pat[idx];
      else b = 1'b1;
      idx++;
      mem.resp_i  = b;
      mem.burst_i = b ? data[k*s_burst +: s_burst] : {$urandom, $urandom};
      if (b) begin
        o.beatData[k] = mem.burst_o;
        k++;
      end
      o.slots++;
      @(negedge clk);
      o.cycles++;
      mem.resp_i = 1'b0;
    end
    if (k < beats) o.timeout = 1'b1;
    o.respDone     = resp_o;
    o.strobeAtDone = mem.read_o | mem.write_o;
    o.line         = line_o;
    if (mem.address_o !== o.addr) o.addrMoved = 1'b1;
    if (!hold) begin
      read_i  = 1'b0;
      write_i = 1'b0;
    end
    mem.resp_i = 1'($urandom_range(0, 1));
    @(negedge clk);
    o.idleBusy = resp_o | mem.read_o | mem.write_o;
    mem.resp_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    read_i = 1'b1;
    write_i = 1'b0;
    address_i = 32'hFFFF_FFFF;
    line_i = rand256();
    mem.resp_i = 1'b1;
    mem.burst_i = {$urandom, $urandom};
    repeat (3) @(negedge clk);
    checks++;
    if (line_o !== '0) begin
      errors++;
      $display("[TB] FAIL reset_line got=%h want=0", line_o);
    end
    checks++;
    if ({resp_o, mem.read_o, mem.write_o} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_strobes got=%b want=000", {resp_o, mem.read_o, mem.write_o});
    end
    checks++;
    if (mem.address_o !== '0 || mem.burst_o !== '0) begin
      errors++;
      $display("[TB] FAIL reset_bus got addr=%h burst=%h want 0", mem.address_o, mem.burst_o);
    end
    read_i = 1'b0;
    mem.resp_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    mem.resp_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({resp_o, mem.read_o, mem.write_o} !== 3'b000 || line_o !== '0) begin
      errors++;
      $display("[TB] FAIL reset_release_idle got=%b line=%h want idle", {resp_o, mem.read_o, mem.write_o}, line_o);
    end
    mem.resp_i = 1'b0;
    modelFill = '0;
  endtask

  task automatic test_fill();
    obs_t o;
    logic [s_line-1:0] d;
    d = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    doTxn(1'b0, 1'b0, 32'h1234_5678, d, 1'b0, 0, 0, 1'b0, o);
    modelFill = d;
    checks++;
    if (o.addr !== 32'h1234_5660 || o.addrMoved) begin
      errors++;
      $display("[TB] FAIL fill_addr got=%h moved=%0d want=12345660", o.addr, o.addrMoved);
    end
    checks++;
    if (o.line !== d) begin
      errors++;
      $display("[TB] FAIL fill_line got=%h want=%h", o.line, d);
    end
    checks++;
    if (!o.respDone || o.strobeAtDone || o.respEarly || o.timeout) begin
      errors++;
      $display("[TB] FAIL fill_resp got done=%0d strobe=%0d early=%0d to=%0d want 1 0 0 0",
               o.respDone, o.strobeAtDone, o.respEarly, o.timeout);
    end
    checks++;
    if (o.cycles !== beats + 2) begin
      errors++;
      $display("[TB] FAIL fill_latency got=%0d want=%0d", o.cycles, beats + 2);
    end
    checks++;
    if (!o.strobeOk || o.otherStrobe || o.idleBusy) begin
      errors++;
      $display("[TB] FAIL fill_strobes got ok=%0d other=%0d idlebusy=%0d want 1 0 0",
               o.strobeOk, o.otherStrobe, o.idleBusy);
    end
  endtask

  task automatic test_writeback();
    obs_t o;
    logic [s_line-1:0] d;
    d = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
         64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    doTxn(1'b1, 1'b0, 32'h8000_0047, d, 1'b0, 0, 0, 1'b0, o);
    for (int k = 0; k < beats; k++) begin
      checks++;
      if (o.beatData[k] !== d[k*s_burst +: s_burst]) begin
        errors++;
        $display("[TB] FAIL wb_beat%0d got=%h want=%h", k, o.beatData[k], d[k*s_burst +: s_burst]);
      end
    end
    checks++;
    if (o.addr !== 32'h8000_0040) begin
      errors++;
      $display("[TB] FAIL wb_addr got=%h want=80000040", o.addr);
    end
    checks++;
    if (!o.respDone || o.strobeAtDone || o.respEarly || !o.strobeOk || o.otherStrobe) begin
      errors++;
      $display("[TB] FAIL wb_handshake got done=%0d strobe=%0d early=%0d ok=%0d other=%0d",
               o.respDone, o.strobeAtDone, o.respEarly, o.strobeOk, o.otherStrobe);
    end
    checks++;
    if (o.line !== modelFill) begin
      errors++;
      $display("[TB] FAIL wb_fill_line_kept got=%h want=%h", o.line, modelFill);
    end
  endtask

  task automatic test_gapped_fill();
    obs_t o;
    logic [s_line-1:0] d;
    d = rand256();
    // resp_i sequence 1,0,1,0,0,1,1 (bit 0 first)
    doTxn(1'b0, 1'b0, 32'h0000_1F3C, d, 1'b0, 32'h65, 7, 1'b0, o);
    modelFill = d;
    checks++;
    if (o.line !== d) begin
      errors++;
      $display("[TB] FAIL gap_line got=%h want=%h", o.line, d);
    end
    checks++;
    if (o.respEarly || !o.respDone || o.cycles !== 9) begin
      errors++;
      $display("[TB] FAIL gap_resp got early=%0d done=%0d cycles=%0d want 0 1 9",
               o.respEarly, o.respDone, o.cycles);
    end
  endtask

  task automatic test_priority();
    obs_t o;
    logic [s_line-1:0] d;
    d = rand256();
    doTxn(1'b1, 1'b1, 32'h4000_0010, d, 1'b0, 0, 0, 1'b0, o);
    checks++;
    if (o.otherStrobe || !o.strobeOk) begin
      errors++;
      $display("[TB] FAIL prio_strobe got read_seen=%0d write_ok=%0d want 0 1", o.otherStrobe, o.strobeOk);
    end
    checks++;
    if (o.beatData !== d) begin
      errors++;
      $display("[TB] FAIL prio_beats got=%h want=%h", o.beatData, d);
    end
    checks++;
    if (o.line !== modelFill) begin
      errors++;
      $display("[TB] FAIL prio_fill_line_kept got=%h want=%h", o.line, modelFill);
    end
  endtask

  task automatic test_reset_midburst();
    obs_t o;
    logic [s_line-1:0] d;
    address_i = 32'h0000_0ABC;
    read_i = 1'b1;
    write_i = 1'b0;
    mem.resp_i = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      mem.resp_i = 1'b1;
      mem.burst_i = {$urandom, $urandom};
      @(negedge clk);
    end
    mem.resp_i = 1'b0;
    #2;
    rst = 1'b0;
    read_i = 1'b0;
    #1;
    checks++;
    if ({resp_o, mem.read_o, mem.write_o} !== 3'b000 || mem.address_o !== '0 || mem.burst_o !== '0) begin
      errors++;
      $display("[TB] FAIL midrst_async got strobes=%b addr=%h burst=%h want 0",
               {resp_o, mem.read_o, mem.write_o}, mem.address_o, mem.burst_o);
    end
    checks++;
    if (line_o !== '0) begin
      errors++;
      $display("[TB] FAIL midrst_line got=%h want=0", line_o);
    end
    @(negedge clk);
    rst = 1'b1;
    modelFill = '0;
    @(negedge clk);
    d = rand256();
    doTxn(1'b0, 1'b0, 32'h0000_0ABC, d, 1'b0, 0, 0, 1'b0, o);
    modelFill = d;
    checks++;
    if (o.line !== d || o.cycles !== beats + 2) begin
      errors++;
      $display("[TB] FAIL midrst_refill got=%h cycles=%0d want=%h cycles=%0d", o.line, o.cycles, d, beats + 2);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o1;
    obs_t o2;
    logic [s_line-1:0] d1;
    logic [s_line-1:0] d2;
    d1 = rand256();
    d2 = rand256();
    doTxn(1'b0, 1'b0, 32'h0BAD_F00D, d1, 1'b0, 0, 0, 1'b1, o1);
    doTxn(1'b0, 1'b0, 32'h0BAD_F00D, d2, 1'b0, 0, 0, 1'b0, o2);
    modelFill = d2;
    checks++;
    if (o1.line !== d1 || o1.idleBusy) begin
      errors++;
      $display("[TB] FAIL b2b_first got=%h idlebusy=%0d want=%h 0", o1.line, o1.idleBusy, d1);
    end
    checks++;
    if (o2.line !== d2 || !o2.strobeOk || o2.cycles !== beats + 2) begin
      errors++;
      $display("[TB] FAIL b2b_second got=%h ok=%0d cycles=%0d want=%h 1 %0d",
               o2.line, o2.strobeOk, o2.cycles, d2, beats + 2);
    end
  endtask

  task automatic test_random();
    obs_t o;
    bit isWrite;
    logic [s_addr-1:0] a;
    logic [s_line-1:0] d;
    for (int i = 0; i < 16; i++) begin
      isWrite = 1'($urandom_range(0, 1));
      a = $urandom;
      d = rand256();
      doTxn(isWrite, 1'($urandom_range(0, 1)), a, d, 1'b1, 0, 0, 1'($urandom_range(0, 1)), o);
      checks++;
      if (isWrite) begin
        if (o.beatData !== d || o.line !== modelFill) begin
          errors++;
          $display("[TB] FAIL rand%0d_wb got beats=%h line=%h want beats=%h line=%h",
                   i, o.beatData, o.line, d, modelFill);
        end
      end else begin
        modelFill = d;
        if (o.line !== d) begin
          errors++;
          $display("[TB] FAIL rand%0d_fill got=%h want=%h", i, o.line, d);
        end
      end
      checks++;
      if (o.addr !== expAddr(a) || o.addrMoved) begin
        errors++;
        $display("[TB] FAIL rand%0d_addr got=%h moved=%0d want=%h", i, o.addr, o.addrMoved, expAddr(a));
      end
      checks++;
      if (!o.respDone || o.strobeAtDone || o.respEarly || o.timeout || !o.strobeOk ||
          o.otherStrobe || o.cycles !== o.slots + 2) begin
        errors++;
        $display("[TB] FAIL rand%0d_proto got done=%0d sd=%0d early=%0d to=%0d ok=%0d other=%0d cycles=%0d want cycles=%0d",
                 i, o.respDone, o.strobeAtDone, o.respEarly, o.timeout, o.strobeOk,
                 o.otherStrobe, o.cycles, o.slots + 2);
      end
    end
    read_i = 1'b0;
    write_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_writeback();
    test_gapped_fill();
    test_priority();
    test_reset_midburst();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
